fir_sample_streamer: RTL and testbench

- Initiator side of the FIR core's inputValid/outputValid handshake.
- Reads NUM_SAMPLES input samples from a sample RAM and presents each one to the FIR core with a one-cycle inputValid pulse.
- Waits for the matching outputValid, captures the filter result and writes it to a result RAM.
- Sits between the testbench/host memory and the FIR datapath plus controller; also guards against a hung FIR with a watchdog.

---
 rtl/fir_sample_streamer.sv | 119 +++++++++++
 tb/tb_fir_sample_streamer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_sample_streamer.sv
// Streams samples from a sample RAM into the FIR core one at a time and
// writes each filter result back to a result RAM, with a watchdog for a hung FIR.
module fir_sample_streamer #(
  parameter int DATA_W  = 16,
  parameter int OUT_W   = 38,
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 127
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] numSamples,
  output logic              busy,
  output logic              done,
  output logic              timeoutErr,
  output logic [ADDR_W-1:0] memAddr,
  input  logic [DATA_W-1:0] memData,
  output logic [DATA_W-1:0] firInput,
  output logic              inputValid,
  input  logic [OUT_W-1:0]  firOutput,
  input  logic              outputValid,
  output logic [ADDR_W-1:0] resAddr,
  output logic [OUT_W-1:0]  resData,
  output logic              resWe
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    ISSUE,
    WAIT,
    STORE,
    DONE
  } state_t;

  state_t            state;
  state_t            nextState;
  logic [ADDR_W-1:0] runLen;
  logic [ADDR_W-1:0] index;
  logic [ADDR_W-1:0] indexInc;
  logic [WD_W-1:0]   watchdog;
  logic              terminal;

  assign indexInc = index + 1'b1;
  assign terminal = (watchdog == WD_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // outputValid beats the watchdog when both land in the same WAIT cycle
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (start) nextState = (numSamples == '0) ? DONE : FETCH;
      FETCH:   nextState = LOAD;
      LOAD:    nextState = ISSUE;
      ISSUE:   nextState = WAIT;
      WAIT: begin
        if (outputValid)   nextState = STORE;
        else if (terminal) nextState = DONE;
      end
      STORE:   nextState = (indexInc == runLen) ? DONE : FETCH;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Strobes are decoded from nextState so each one is high exactly while the
  // FSM sits in the matching state. The watchdog is cleared on entry to ISSUE
  // and counts on every entry into WAIT, so it reads k in the k-th WAIT cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      runLen     <= '0;
      index      <= '0;
      watchdog   <= '0;
      firInput   <= '0;
      memAddr    <= '0;
      resAddr    <= '0;
      resData    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      inputValid <= 1'b0;
      resWe      <= 1'b0;
      timeoutErr <= 1'b0;
    end else begin
      busy       <= (nextState != IDLE);
      done       <= (nextState == DONE);
      inputValid <= (nextState == ISSUE);
      resWe      <= (nextState == STORE);

      if (state == IDLE && start) begin
        runLen     <= numSamples;
        index      <= '0;
        timeoutErr <= 1'b0;
      end

      if (nextState == FETCH) memAddr <= (state == STORE) ? indexInc : '0;
      if (state == LOAD) firInput <= memData;

      if (nextState == ISSUE)     watchdog <= '0;
      else if (nextState == WAIT) watchdog <= watchdog + 1'b1;

      if (state == WAIT && outputValid) resData <= firOutput;
      if (state == WAIT && !outputValid && terminal) timeoutErr <= 1'b1;

      if (nextState == STORE) resAddr <= index;
      if (state == STORE) index <= indexInc;
    end
  end

endmodule

// File: tb/tb_fir_sample_streamer.sv
// Directed bench for fir_sample_streamer: RAM model, a behavioural FIR
// responder with programmable latency, and a negedge monitor.
module tb_fir_sample_streamer;

  localparam int DATA_W  = 16;
  localparam int OUT_W   = 38;
  localparam int ADDR_W  = 10;
  localparam int TIMEOUT = 127;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] numSamples;
  logic              busy;
  logic              done;
  logic              timeoutErr;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memData;
  logic [DATA_W-1:0] firInput;
  logic              inputValid;
  logic [OUT_W-1:0]  firOutput;
  logic              outputValid;
  logic [ADDR_W-1:0] resAddr;
  logic [OUT_W-1:0]  resData;
  logic              resWe;

  fir_sample_streamer #(
    .DATA_W(DATA_W), .OUT_W(OUT_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .numSamples(numSamples),
    .busy(busy), .done(done), .timeoutErr(timeoutErr),
    .memAddr(memAddr), .memData(memData), .firInput(firInput),
    .inputValid(inputValid), .firOutput(firOutput), .outputValid(outputValid),
    .resAddr(resAddr), .resData(resData), .resWe(resWe)
  );

  always #5 clk = ~clk;

  int passCount = 0;
  int totalCount = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // sample RAM with one cycle of read latency
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) memData <= mem[memAddr];

  // FIR responder: mode 0 never answers, 1 returns 38'h123, 2 returns input*2
  int               modelMode = 0;
  int               modelLat  = 66;
  logic             modelValid = 1'b0;
  logic [OUT_W-1:0] modelData = '0;
  logic             forceValid;
  logic [OUT_W-1:0] forceData;
  logic             pending = 1'b0;
  int               cnt = 0;
  logic [DATA_W-1:0] capIn = '0;

  assign outputValid = modelValid | forceValid;
  assign firOutput   = forceValid ? forceData : modelData;

  always @(negedge clk) begin
    modelValid = 1'b0;
    if (!rst) begin
      pending = 1'b0;
    end else begin
      if (pending) begin
        cnt--;
        if (cnt == 0) begin
          modelValid = 1'b1;
          modelData  = (modelMode == 2) ? OUT_W'(capIn) * 2 : 38'h123;
          pending    = 1'b0;
        end
      end
      if (inputValid && modelMode != 0) begin
        pending = 1'b1;
        cnt     = modelLat;
        capIn   = firInput;
      end
    end
  end

  // monitor: records every issue and every result write
  logic [63:0] ivAddrQ[$];
  logic [63:0] ivDataQ[$];
  logic [63:0] ivCycQ[$];
  logic [63:0] weAddrQ[$];
  logic [63:0] weDataQ[$];
  logic [63:0] weFirQ[$];

  always @(negedge clk) begin
    if (rst) begin
      if (inputValid) begin
        ivAddrQ.push_back(64'(memAddr));
        ivDataQ.push_back(64'(firInput));
        ivCycQ.push_back(64'(cyc));
      end
      if (resWe) begin
        weAddrQ.push_back(64'(resAddr));
        weDataQ.push_back(64'(resData));
        weFirQ.push_back(64'(firInput));
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    totalCount++;
    assert (obs === exp) passCount++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic applyStimulus(input logic [ADDR_W-1:0] n);
    @(negedge clk);
    numSamples = n;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  int doneAt;
  task automatic waitDone(input int budget, input string tag);
    int k;
    k = 0;
    while (!done && k < budget) begin
      @(negedge clk);
      k++;
    end
    doneAt = cyc;
    checkOutput({tag, "_doneSeen"}, 64'(done), 64'd1);
  endtask

  int ivBase, weBase;

  initial begin
    rst = 1'b0; start = 1'b0; numSamples = '0;
    forceValid = 1'b0; forceData = '0;
    for (int i = 0; i < (1<<ADDR_W); i++) mem[i] = '0;
    repeat (3) @(negedge clk);

    checkOutput("resetStrobes", {busy, done, inputValid, resWe, timeoutErr}, 5'b0);
    checkOutput("resetMemAddr", 64'(memAddr), 0);
    checkOutput("resetFirInput", 64'(firInput), 0);
    checkOutput("resetRes", {resAddr, resData}, 0);
    rst = 1'b1;

    // single sample, constant FIR answer
    mem[0] = 16'h0005; modelMode = 1; modelLat = 66;
    ivBase = ivAddrQ.size(); weBase = weAddrQ.size();
    applyStimulus(1);
    checkOutput("single_busyHigh", 64'(busy), 1);
    waitDone(200, "single");
    checkOutput("single_ivCount", 64'(ivAddrQ.size() - ivBase), 1);
    checkOutput("single_firInput", ivDataQ[ivBase], 5);
    checkOutput("single_weCount", 64'(weAddrQ.size() - weBase), 1);
    checkOutput("single_resAddr", weAddrQ[weBase], 0);
    checkOutput("single_resData", weDataQ[weBase], 38'h123);
    @(negedge clk);
    checkOutput("single_afterDone", {busy, done}, 2'b00);

    // four samples, echo x2
    for (int i = 0; i < 4; i++) mem[i] = 16'(i + 1);
    modelMode = 2;
    ivBase = ivAddrQ.size(); weBase = weAddrQ.size();
    applyStimulus(4);
    waitDone(400, "four");
    checkOutput("four_ivCount", 64'(ivAddrQ.size() - ivBase), 4);
    checkOutput("four_weCount", 64'(weAddrQ.size() - weBase), 4);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("four_memAddr%0d", i), ivAddrQ[ivBase+i], 64'(i));
      checkOutput($sformatf("four_resAddr%0d", i), weAddrQ[weBase+i], 64'(i));
      checkOutput($sformatf("four_resData%0d", i), weDataQ[weBase+i], 64'(2*(i+1)));
      checkOutput($sformatf("four_firStable%0d", i), weFirQ[weBase+i], 64'(i+1));
      if (i > 0)
        checkOutput($sformatf("four_spacing%0d", i), ivCycQ[ivBase+i] - ivCycQ[ivBase+i-1], 70);
    end

    // zero length: done on the second cycle counting the start cycle
    ivBase = ivAddrQ.size(); weBase = weAddrQ.size();
    @(negedge clk);
    numSamples = '0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("zero_doneHigh", 64'(done), 1);
    @(negedge clk);
    checkOutput("zero_doneLowBusyLow", {busy, done}, 2'b00);
    checkOutput("zero_memAddrHeld", 64'(memAddr), 3);
    checkOutput("zero_noIssueNoWrite", 64'((ivAddrQ.size() - ivBase) + (weAddrQ.size() - weBase)), 0);

    // timeout with a silent FIR, then a clean restart
    mem[0] = 16'h0007; modelMode = 0;
    ivBase = ivAddrQ.size(); weBase = weAddrQ.size();
    applyStimulus(1);
    waitDone(300, "timeout");
    checkOutput("timeout_err", 64'(timeoutErr), 1);
    checkOutput("timeout_latency", 64'(doneAt) - ivCycQ[ivBase], 64'(TIMEOUT));
    checkOutput("timeout_noWrite", 64'(weAddrQ.size() - weBase), 0);
    modelMode = 1;
    applyStimulus(1);
    checkOutput("timeout_errCleared", 64'(timeoutErr), 0);
    waitDone(200, "recover");
    checkOutput("recover_write", 64'(weAddrQ.size() - weBase), 1);

    // race: answer lands on the watchdog terminal cycle
    modelMode = 1; modelLat = TIMEOUT - 1;
    weBase = weAddrQ.size();
    applyStimulus(1);
    waitDone(300, "race");
    checkOutput("race_noErr", 64'(timeoutErr), 0);
    checkOutput("race_write", 64'(weAddrQ.size() - weBase), 1);
    checkOutput("race_data", weDataQ[weBase], 38'h123);

    // stray outputValid in IDLE
    weBase = weAddrQ.size();
    @(negedge clk);
    forceData = 38'hABC; forceValid = 1'b1;
    @(negedge clk);
    forceValid = 1'b0;
    @(negedge clk);
    checkOutput("idleValid_ignored", {64'(weAddrQ.size() - weBase), 1'b0, busy}, 0);

    // stray start in WAIT
    mem[0] = 16'h0009; modelMode = 2; modelLat = 66;
    ivBase = ivAddrQ.size(); weBase = weAddrQ.size();
    applyStimulus(1);
    repeat (10) @(negedge clk);
    numSamples = 10'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone(200, "waitStart");
    checkOutput("waitStart_ivCount", 64'(ivAddrQ.size() - ivBase), 1);
    checkOutput("waitStart_data", weDataQ[weBase], 18);
    @(negedge clk);
    checkOutput("waitStart_idleAfter", 64'(busy), 0);

    // async reset while waiting on sample 2, then a clean rerun
    for (int i = 0; i < 4; i++) mem[i] = 16'(i + 1);
    ivBase = ivAddrQ.size(); weBase = weAddrQ.size();
    applyStimulus(3);
    for (int k = 0; k < 300 && ivAddrQ.size() < ivBase + 2; k++) @(negedge clk);
    checkOutput("rstMid_reachedSample2", 64'(ivAddrQ.size() - ivBase), 2);
    repeat (10) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checkOutput("rstMid_strobes", {busy, done, inputValid, resWe, timeoutErr}, 5'b0);
    checkOutput("rstMid_addrs", {memAddr, resAddr}, 0);
    checkOutput("rstMid_data", {firInput, resData}, 0);
    repeat (3) @(negedge clk);
    checkOutput("rstMid_noDone", 64'(done), 0);
    rst = 1'b1;
    checkOutput("rstMid_oneWrite", 64'(weAddrQ.size() - weBase), 1);
    ivBase = ivAddrQ.size(); weBase = weAddrQ.size();
    applyStimulus(2);
    waitDone(300, "rerun");
    checkOutput("rerun_ivCount", 64'(ivAddrQ.size() - ivBase), 2);
    checkOutput("rerun_addr0", ivAddrQ[ivBase], 0);
    checkOutput("rerun_addr1", ivAddrQ[ivBase+1], 1);
    checkOutput("rerun_data0", weDataQ[weBase], 2);
    checkOutput("rerun_data1", weDataQ[weBase+1], 4);

    $display("[TB] %0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL simTimeout: observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit");
  end

endmodule
